// File: rtl/light_timer_pkg.sv
// -----------------------------------------------------------------------------
// light_timer_pkg
// Shared definitions for the traffic-light phase timer: the phase state
// encoding and the default timing constants.
// No ports (package).
// -----------------------------------------------------------------------------
package light_timer_pkg;

   typedef enum logic [1:0] {
      RUN_SHORT = 2'd0,
      RUN_LONG  = 2'd1,
      DONE      = 2'd2
   } phase_t;

   localparam int DEF_CLK_DIV     = 100000000;  // 1 s tick at 100 MHz
   localparam int DEF_SHORT_TICKS = 5;          // yellow interval
   localparam int DEF_LONG_TICKS  = 25;         // green interval
   localparam int SIM_CLK_DIV     = 4;          // short tick period for benches

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to a one-cycle strobe every CLK_DIV cycles.
// Ports:
//   clk   in   system clock
//   reset in   asynchronous, active-high reset
//   clr   in   synchronous clear (restart); suppresses any wrap on that edge
//   tick  out  registered strobe, high for one cycle after each wrap
//   wrap  out  combinational: the coming edge wraps the counter (tick's D input)
// -----------------------------------------------------------------------------
module tick_prescaler #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick,
   output logic wrap
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [PW-1:0] pre;

   // A clear on the wrap edge discards that tick.
   assign wrap = !clr && (pre == PW'(CLK_DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre  <= '0;
         tick <= 1'b0;
      end else if (clr) begin
         pre  <= '0;
         tick <= 1'b0;
      end else if (wrap) begin
         pre  <= '0;
         tick <= 1'b1;
      end else begin
         pre  <= pre + PW'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/light_phase_timer.sv
// -----------------------------------------------------------------------------
// light_phase_timer
// Timing stage for the traffic-light FSM. After a start pulse it raises ts
// after SHORT_TICKS prescaler ticks and tl after LONG_TICKS ticks; both stay
// high until the next start or reset.
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous, active-high reset (behaves like a start)
//   st      in   start/restart; held high keeps everything cleared
//   ts      out  short timeout reached (registered, sticky)
//   tl      out  long timeout reached (registered, sticky)
//   elapsed out  ticks since last start, saturating at LONG_TICKS
//   tick    out  one-cycle prescaler strobe
// -----------------------------------------------------------------------------
module light_phase_timer
   import light_timer_pkg::*;
#(
   parameter int CLK_DIV     = DEF_CLK_DIV,
   parameter int SHORT_TICKS = DEF_SHORT_TICKS,
   parameter int LONG_TICKS  = DEF_LONG_TICKS,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             st,
   output logic             ts,
   output logic             tl,
   output logic [CNT_W-1:0] elapsed,
   output logic             tick
);

   if (LONG_TICKS <= SHORT_TICKS) begin : g_bad_order
      $error("LONG_TICKS must exceed SHORT_TICKS");
   end
   if (CLK_DIV < 2) begin : g_bad_div
      $error("CLK_DIV must be at least 2");
   end
   if (LONG_TICKS >= (2 ** CNT_W)) begin : g_bad_width
      $error("CNT_W too narrow for LONG_TICKS");
   end

   localparam logic [CNT_W-1:0] SHORT_C = CNT_W'(SHORT_TICKS);
   localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_TICKS);

   logic             wrap;
   phase_t           state, state_d;
   logic [CNT_W-1:0] elapsed_d, elapsed_inc;
   logic             ts_d, tl_d;

   tick_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clr   (st),
      .tick  (tick),
      .wrap  (wrap)
   );

   assign elapsed_inc = elapsed + CNT_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= RUN_SHORT;
         elapsed <= '0;
         ts      <= 1'b0;
         tl      <= 1'b0;
      end else begin
         state   <= state_d;
         elapsed <= elapsed_d;
         ts      <= ts_d;
         tl      <= tl_d;
      end
   end

   // wrap is already gated by st, so restart always wins over a counting step.
   always_comb begin
      state_d   = state;
      elapsed_d = elapsed;
      ts_d      = ts;
      tl_d      = tl;
      if (st) begin
         state_d   = RUN_SHORT;
         elapsed_d = '0;
         ts_d      = 1'b0;
         tl_d      = 1'b0;
      end else if (wrap) begin
         case (state)
            RUN_SHORT: begin
               elapsed_d = elapsed_inc;
               if (elapsed_inc == SHORT_C) begin
                  ts_d    = 1'b1;
                  state_d = RUN_LONG;
               end
            end
            RUN_LONG: begin
               elapsed_d = elapsed_inc;
               if (elapsed_inc == LONG_C) begin
                  tl_d    = 1'b1;
                  state_d = DONE;
               end
            end
            DONE: begin
               // Saturated: elapsed, ts and tl hold.
            end
            default: begin
               state_d = RUN_SHORT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_light_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_light_phase_timer
// Directed bench for light_phase_timer with CLK_DIV=4, SHORT_TICKS=2,
// LONG_TICKS=5. Expected outputs are computed from the number of clock edges
// since the last restart (reset release or st edge).
// -----------------------------------------------------------------------------
module tb_light_phase_timer;
   import light_timer_pkg::*;

   localparam int DIV   = SIM_CLK_DIV;
   localparam int SHORT = 2;
   localparam int LONG  = 5;
   localparam int CW    = 8;

   logic          clk;
   logic          reset;
   logic          st;
   logic          ts;
   logic          tl;
   logic [CW-1:0] elapsed;
   logic          tick;

   int checks;
   int failures;

   light_phase_timer #(
      .CLK_DIV     (DIV),
      .SHORT_TICKS (SHORT),
      .LONG_TICKS  (LONG),
      .CNT_W       (CW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .st      (st),
      .ts      (ts),
      .tl      (tl),
      .elapsed (elapsed),
      .tick    (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Expected outputs n edges after a restart, with st low since.
   task automatic check_at(input string scen, input int n);
      int e_el;
      e_el = n / DIV;
      if (e_el > LONG) e_el = LONG;
      check($sformatf("%s n=%0d elapsed", scen, n), 32'(elapsed), 32'(e_el));
      check($sformatf("%s n=%0d ts", scen, n), 32'(ts), 32'(n >= SHORT * DIV));
      check($sformatf("%s n=%0d tl", scen, n), 32'(tl), 32'(n >= LONG * DIV));
      check($sformatf("%s n=%0d tick", scen, n), 32'(tick), 32'(n > 0 && (n % DIV) == 0));
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Pulse st for one edge and check the cleared condition after it.
   task automatic pulse_st(input string scen);
      st = 1'b1;
      step();
      st = 1'b0;
      check_at(scen, 0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      st       = 1'b0;

      // Reset state and free run
      repeat (3) step();
      check_at("reset", 0);
      reset = 1'b0;
      for (int n = 1; n <= 30; n++) begin
         step();
         check_at("freerun", n);
      end

      // st pulse while in DONE
      pulse_st("st_done");
      for (int n = 1; n <= 24; n++) begin
         step();
         check_at("after_st", n);
      end

      // st coincident with a prescaler wrap (edge 28 would wrap)
      for (int n = 25; n <= 27; n++) begin
         step();
         check_at("pre_wrap", n);
      end
      pulse_st("st_on_wrap");
      for (int n = 1; n <= 10; n++) begin
         step();
         check_at("after_wrap_st", n);
      end

      // st held for 10 cycles
      st = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check_at("st_held", 0);
      end
      st = 1'b0;
      for (int n = 1; n <= 22; n++) begin
         step();
         check_at("after_hold", n);
      end

      // Asynchronous reset mid-cycle at elapsed=3 (RUN_LONG)
      pulse_st("st_pre_reset");
      for (int n = 1; n <= 13; n++) begin
         step();
         check_at("pre_reset", n);
      end
      #2 reset = 1'b1;
      #1;
      check("async_reset elapsed", 32'(elapsed), 32'd0);
      check("async_reset ts", 32'(ts), 32'd0);
      check("async_reset tl", 32'(tl), 32'd0);
      check("async_reset tick", 32'(tick), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         step();
         check_at("after_reset", n);
      end

      // Long run into and through DONE
      for (int n = 11; n <= 220; n++) begin
         step();
         check_at("long_run", n);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
